// File: rtl/wmul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wmul_pkg
// Purpose : Shared widths, FSM state encoding and small helpers for the
//           shared Wallace multiplier controller.
// Revision: 1.0 - initial release
// ============================================================================
package wmul_pkg;

  localparam int OPW = 16;  // operand width
  localparam int PW  = 32;  // product width
  localparam int IDW = 3;   // requester index width (up to 8 requesters)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of a down-counter that must hold the value n (at least 1 bit).
  function automatic int wait_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // 3:2 carry-save compressor on whole words; returns {carry, sum}.
  // The carry out of the top bit is dropped: every product fits in PW bits.
  function automatic logic [2*PW-1:0] csa3(input logic [PW-1:0] x,
                                           input logic [PW-1:0] y,
                                           input logic [PW-1:0] z);
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wallace16x16_struct.sv
`default_nettype none
// ============================================================================
// Module  : wallace16x16_struct
// Purpose : Purely combinational 16x16 unsigned multiplier. Partial products
//           are reduced 16->11->8->6->4->3->2 by carry-save compressors and
//           finished with a ripple-carry adder. Deliberately slow; the caller
//           treats it as a multicycle path.
// Revision: 1.0 - initial release
// ============================================================================
module wallace16x16_struct
  import wmul_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  p
);

  logic [PW-1:0] pp [OPW];
  logic [PW-1:0] l1 [11];
  logic [PW-1:0] l2 [8];
  logic [PW-1:0] l3 [6];
  logic [PW-1:0] l4 [4];
  logic [PW-1:0] l5 [3];
  logic [PW-1:0] l6 [2];
  logic [PW-1:0] cy;

  // One shifted copy of A per bit of B.
  for (genvar i = 0; i < OPW; i++) begin : g_pp
    assign pp[i] = b[i] ? (PW'(a) << i) : '0;
  end

  // Carry-save reduction tree, leftover rows pass straight through.
  always_comb begin
    logic [2*PW-1:0] t;
    t = '0;
    for (int k = 0; k < 5; k++) begin
      t = csa3(pp[3*k], pp[3*k+1], pp[3*k+2]);
      l1[2*k]   = t[PW-1:0];
      l1[2*k+1] = t[2*PW-1:PW];
    end
    l1[10] = pp[15];
    for (int k = 0; k < 3; k++) begin
      t = csa3(l1[3*k], l1[3*k+1], l1[3*k+2]);
      l2[2*k]   = t[PW-1:0];
      l2[2*k+1] = t[2*PW-1:PW];
    end
    l2[6] = l1[9];
    l2[7] = l1[10];
    for (int k = 0; k < 2; k++) begin
      t = csa3(l2[3*k], l2[3*k+1], l2[3*k+2]);
      l3[2*k]   = t[PW-1:0];
      l3[2*k+1] = t[2*PW-1:PW];
    end
    l3[4] = l2[6];
    l3[5] = l2[7];
    for (int k = 0; k < 2; k++) begin
      t = csa3(l3[3*k], l3[3*k+1], l3[3*k+2]);
      l4[2*k]   = t[PW-1:0];
      l4[2*k+1] = t[2*PW-1:PW];
    end
    t = csa3(l4[0], l4[1], l4[2]);
    l5[0] = t[PW-1:0];
    l5[1] = t[2*PW-1:PW];
    l5[2] = l4[3];
    t = csa3(l5[0], l5[1], l5[2]);
    l6[0] = t[PW-1:0];
    l6[1] = t[2*PW-1:PW];
  end

  // Final carry-propagate stage as an explicit ripple chain.
  assign cy[0] = 1'b0;
  for (genvar i = 0; i < PW; i++) begin : g_rca
    assign p[i] = l6[0][i] ^ l6[1][i] ^ cy[i];
    if (i < PW - 1) begin : g_carry
      assign cy[i+1] = (l6[0][i] & l6[1][i]) | (l6[0][i] & cy[i]) | (l6[1][i] & cy[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wmul_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : wmul_rr_pick
// Purpose : Combinational round-robin picker. Searches req_valid upward from
//           rr_ptr (modulo NREQ) and returns the first hit as one-hot and index.
// Revision: 1.0 - initial release
// ============================================================================
module wmul_rr_pick
  import wmul_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  // Walk candidates from farthest to nearest so the nearest one wins last.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        any_valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wmul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : wmul_share_ctrl
// Purpose : Shares one combinational Wallace multiplier between NREQ
//           requesters with round-robin arbitration, one transaction in
//           flight. Operands are held WAIT_CYC cycles before the product is
//           registered and offered on the shared response channel.
//           Optional per-requester grant counters: WMUL_SHARE_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module wmul_share_ctrl
  import wmul_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [PW-1:0]       rsp_p,
  output logic                busy
`ifdef WMUL_SHARE_STATS_EN
  ,
  output logic [NREQ*16-1:0]  stat_grants
`endif
);

  localparam int CW = wait_cnt_w(WAIT_CYC);

  if (WAIT_CYC < 1 || NREQ < 1 || NREQ > 8) begin : g_param_check
    $error("wmul_share_ctrl: WAIT_CYC must be >= 1 and NREQ in 1..8");
  end

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id;
  logic [CW-1:0]  cnt;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic [PW-1:0]  mult_p;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_idx;
  logic           any_valid;
  logic [IDW-1:0] next_ptr;

  wmul_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  wallace16x16_struct u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult_p)
  );

  // Grants are only offered while idle and never during reset.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign busy      = (state != IDLE);
  assign next_ptr  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Arbitration / settle / response FSM with its operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_a   <= req_a[int'(grant_idx)*OPW +: OPW];
            op_b   <= req_b[int'(grant_idx)*OPW +: OPW];
            id     <= grant_idx;
            cnt    <= CW'(WAIT_CYC);
            rr_ptr <= next_ptr;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            rsp_p     <= mult_p;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WMUL_SHARE_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] grants;
    // Saturating count of accepted requests from requester i.
    always_ff @(posedge clk) begin
      if (rst) begin
        grants <= '0;
      end else if (req_valid[i] && req_ready[i] && grants != 16'hFFFF) begin
        grants <= grants + 16'd1;
      end
    end
    assign stat_grants[i*16 +: 16] = grants;
  end
`endif

endmodule
`default_nettype wire
